// File: rtl/sensor_responder_pkg.sv
// Shared definitions for the light-sensor serial responder and its master.
// Holds the state encoding, frame layout constants and frame assembly helper.
package sensor_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int FRAME_BITS  = 16;
    localparam int LEAD_ZEROS  = 3;
    localparam int DATA_BITS   = 8;
    localparam int TRAIL_ZEROS = 5;
    localparam int FRAME_W     = LEAD_ZEROS + DATA_BITS + TRAIL_ZEROS;
    localparam int CNT_W       = 5;

    function automatic logic [FRAME_W-1:0] assemble_frame(input logic [DATA_BITS-1:0] data);
        return {{LEAD_ZEROS{1'b0}}, data, {TRAIL_ZEROS{1'b0}}};
    endfunction

endpackage

// File: rtl/sensor_responder_if.sv
// Sample handshake and serial bus between the sensor host side and the responder.
interface sensor_responder_if;
    import sensor_responder_pkg::*;

    logic                 ncs;
    logic                 sck;
    logic                 sdo;
    logic [DATA_BITS-1:0] sample_data;
    logic                 sample_valid;
    logic                 sample_ready;

    modport master (
        output ncs,
        output sck,
        output sample_data,
        output sample_valid,
        input  sdo,
        input  sample_ready
    );

    modport slave (
        input  ncs,
        input  sck,
        input  sample_data,
        input  sample_valid,
        output sdo,
        output sample_ready
    );

endinterface

// File: rtl/sensor_responder_sync_edge.sv
// Multi-stage synchronizer for an asynchronous level, with one-cycle rise/fall pulses.
// All stages reset to 1, the idle level of both ncs and sck.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            logic stage_d;
            if (gi == 0) begin : g_first
                assign stage_d = async_i;
            end else begin : g_chain
                assign stage_d = sync_q[gi-1];
            end
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_q[gi] <= 1'b1;
                end else begin
                    sync_q[gi] <= stage_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o =  sync_q[SYNC_STAGES-1] & ~last_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  last_q;

endmodule

// File: rtl/sensor_responder.sv
// Serial light-sensor responder: shifts a held 8-bit sample out as a 16-bit frame
// (3 lead zeros, data MSB first, 5 trail zeros) under a master-driven ncs/sck.
module sensor_responder
    import sensor_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = sensor_responder_pkg::FRAME_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    sensor_responder_if.slave  bus,
    output logic               frame_done,
    output logic               frame_abort
);

    logic ncs_rise, ncs_fall;
    logic sck_rise, sck_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.ncs),
        .rise_o  (ncs_rise),
        .fall_o  (ncs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.sck),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 sdo_q, sdo_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 abort_q, abort_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        abort_d = 1'b0;

        if (bus.sample_valid && ready_q) begin
            hold_d = bus.sample_data;
        end

        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d = SHIFT;
                    shift_d = assemble_frame(hold_q);
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // A deselect outranks any sck edge seen in the same cycle.
                if (ncs_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(FRAME_BITS)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sdo_d   = (state_d != IDLE) ? shift_d[FRAME_W-1] : 1'b0;
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            sdo_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            sdo_q   <= sdo_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign bus.sdo          = sdo_q;
    assign bus.sample_ready = ready_q;
    assign frame_done       = done_q;
    assign frame_abort      = abort_q;

endmodule

// File: tb/tb_sensor_responder.sv
// Scoreboarded bench: stimulus pushes expected frame outcomes, a monitor decodes sdo
// on master sck falling edges and checks each frame_done/frame_abort pulse.
module tb_sensor_responder;

    localparam int H = 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_done, frame_abort;

    always #5 clk = ~clk;

    sensor_responder_if bus ();

    sensor_responder #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    typedef struct {
        logic        is_abort;
        logic [15:0] frame;
        int          nbits;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_done   = 0;
    int   n_abort  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        check("ready_in_idle", int'(bus.sample_ready), 1);
        bus.sample_data  = d;
        bus.sample_valid = 1'b1;
        tick(1);
        bus.sample_valid = 1'b0;
        $display("load sample=0x%02h", d);
        tick(2);
    endtask

    task automatic run_frame(input int rises, input int extra);
        bus.ncs = 1'b0;
        tick(H);
        check("ready_low_in_frame", int'(bus.sample_ready), 0);
        for (int i = 0; i < rises + extra; i++) begin
            bus.sck = 1'b0;
            tick(H);
            bus.sck = 1'b1;
            tick(H);
        end
        bus.ncs = 1'b1;
        tick(H);
    endtask

    function automatic exp_t frame_exp(input logic [7:0] d);
        exp_t e;
        e.is_abort = 1'b0;
        e.frame    = {3'b000, d, 5'b00000};
        e.nbits    = 16;
        return e;
    endfunction

    // Monitor state
    logic        ncs_p = 1'b1, sck_p = 1'b1, done_p = 1'b0, abort_p = 1'b0;
    int          done_len = 0, abort_len = 0, nb = 0;
    logic [15:0] rx = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ncs_p && !bus.ncs) begin
                rx = '0;
                nb = 0;
            end
            if (!bus.ncs && sck_p && !bus.sck) begin
                if (nb >= 16) check("sdo_after_done", int'(bus.sdo), 0);
                else rx = {rx[14:0], bus.sdo};
                nb++;
            end
            if (!bus.ncs && !sck_p && bus.sck && nb >= 16) begin
                check("sdo_after_done", int'(bus.sdo), 0);
            end
            if (frame_done && !done_p) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_done", int'(e.is_abort), 0);
                    check("frame_bits", int'(rx), int'(e.frame));
                    check("bit_count", nb, 16);
                    $display("frame_done rx=0x%04h data=0x%02h bits=%0d", rx, rx[12:5], nb);
                end
            end
            if (frame_abort && !abort_p) begin
                n_abort++;
                if (exp_q.size() == 0) begin
                    check("unexpected_abort", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_abort", int'(e.is_abort), 1);
                    check("abort_bit_count", nb, e.nbits);
                    $display("frame_abort after bits=%0d", nb);
                end
            end
            if (frame_done) done_len++;
            else begin
                if (done_p) check("done_width", done_len, 1);
                done_len = 0;
            end
            if (frame_abort) abort_len++;
            else begin
                if (abort_p) check("abort_width", abort_len, 1);
                abort_len = 0;
            end
            ncs_p   = bus.ncs;
            sck_p   = bus.sck;
            done_p  = frame_done;
            abort_p = frame_abort;
        end
    end

    initial begin
        exp_t ea;
        bus.ncs          = 1'b1;
        bus.sck          = 1'b1;
        bus.sample_data  = '0;
        bus.sample_valid = 1'b0;
        rst_n            = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(1);
        check("reset_sdo", int'(bus.sdo), 0);
        check("reset_ready", int'(bus.sample_ready), 1);
        check("reset_done", int'(frame_done), 0);
        check("reset_abort", int'(frame_abort), 0);
        $display("reset released");

        load(8'hA5);
        exp_q.push_back(frame_exp(8'hA5));
        run_frame(16, 0);

        load(8'hFF);
        load(8'h3C);
        exp_q.push_back(frame_exp(8'h3C));
        run_frame(16, 0);

        ea.is_abort = 1'b1;
        ea.frame    = '0;
        ea.nbits    = 7;
        exp_q.push_back(ea);
        run_frame(7, 0);
        exp_q.push_back(frame_exp(8'h3C));
        run_frame(16, 0);

        load(8'h81);
        exp_q.push_back(frame_exp(8'h81));
        run_frame(16, 0);
        exp_q.push_back(frame_exp(8'h81));
        run_frame(16, 0);

        exp_q.push_back(frame_exp(8'h81));
        run_frame(16, 2);

        // Reset mid-frame while bit 9 (a data 1) is on sdo.
        load(8'hFF);
        bus.ncs = 1'b0;
        tick(H);
        for (int i = 0; i < 8; i++) begin
            bus.sck = 1'b0;
            tick(H);
            bus.sck = 1'b1;
            tick(H);
        end
        bus.sck = 1'b0;
        tick(12);
        check("pre_reset_sdo", int'(bus.sdo), 1);
        rst_n = 1'b0;
        tick(1);
        check("midreset_sdo", int'(bus.sdo), 0);
        check("midreset_ready", int'(bus.sample_ready), 1);
        bus.ncs = 1'b1;
        bus.sck = 1'b1;
        tick(5);
        rst_n = 1'b1;
        tick(H);
        $display("mid-frame reset released");
        exp_q.push_back(frame_exp(8'h00));
        run_frame(16, 0);

        tick(20);
        check("queue_empty", exp_q.size(), 0);
        check("total_done", n_done, 7);
        check("total_abort", n_abort, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_responder.md
SENSOR_RESPONDER -- requirements
Module: sensor_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flop stages on the ncs and sck inputs (minimum 2).
REQ-002 Parameter FRAME_BITS, default 16, number of sck rising edges per frame; fixed layout 3 lead zeros, 8 data bits, 5 trail zeros.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 ncs  input  1  chip select from the master, active low, asynchronous to clk.
REQ-006 sck  input  1  serial clock from the master, idles high, asynchronous to clk.
REQ-007 sdo  output  1  serial data to the master, MSB first.
REQ-008 sample_data  input  8  next light value to transmit.
REQ-009 sample_valid  input  1  sample_data is valid this cycle.
REQ-010 sample_ready  output  1  responder accepts sample_data this cycle.
REQ-011 frame_done  output  1  one-cycle pulse, full frame clocked out.
REQ-012 frame_abort  output  1  one-cycle pulse, ncs deasserted before the frame completed.

Function
REQ-013 ncs and sck SHALL each pass through SYNC_STAGES flip-flops; edge detection SHALL compare the last synchronizer stage with one further registered copy.
REQ-014 States SHALL be IDLE, SHIFT, DONE; the FSM SHALL sit in IDLE whenever synchronized ncs is high and no edge is pending.
REQ-015 sample_ready SHALL be 1 only in IDLE; a handshake (valid and ready) SHALL write sample_data into an 8-bit hold register; later handshakes overwrite it.
REQ-016 IDLE -> SHIFT on synchronized ncs falling edge; in that same cycle shift register SHALL load {3'b000, hold, 5'b00000} and bit counter SHALL clear.
REQ-017 sdo SHALL equal shift register bit 15 in SHIFT and DONE, and 0 in IDLE.
REQ-018 In SHIFT, each synchronized sck rising edge SHALL increment the bit counter (5 bits); each synchronized sck falling edge SHALL shift the register left, inserting 0.
REQ-019 When the counter reaches FRAME_BITS on a rising edge, FSM SHALL go to DONE and frame_done SHALL pulse high for exactly one cycle.
REQ-020 DONE -> IDLE on synchronized ncs rising edge, no pulse; sck edges in DONE SHALL be ignored and sdo SHALL remain 0.
REQ-021 Synchronized ncs rising edge in SHIFT SHALL force IDLE, pulse frame_abort for one cycle, and leave the hold register unchanged.
REQ-022 If ncs rise and an sck edge are detected in the same cycle, ncs SHALL win: the edge is discarded.
REQ-023 ncs falling edge to first valid sdo bit latency SHALL be SYNC_STAGES+1 clk cycles; sck falling edge to next sdo bit likewise.
REQ-024 Correct operation requires each sck half-period and the ncs-low-to-first-sck-rise interval to be at least SYNC_STAGES+3 clk cycles; shorter timing is outside the contract.
REQ-025 Consecutive frames SHALL retransmit the hold value unchanged if no new sample was accepted between them.

Reset
REQ-026 While rst_n is low at posedge clk: FSM = IDLE, hold = 8'h00, shift register = 0, counter = 0, synchronizer stages preset to 1 (ncs, sck idle levels).
REQ-027 Reset outputs: sdo = 0, sample_ready = 1 (from first cycle after reset release), frame_done = 0, frame_abort = 0.
REQ-028 Reset asserted mid-frame SHALL abort silently (no frame_abort pulse); after release a new frame SHALL begin only on a fresh ncs falling edge.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE, SHIFT, DONE), FRAME_BITS, lead/trail zero counts, and the frame-assembly constant widths, for reuse by the existing master.
REQ-030 One sub-module, sync_edge (SYNC_STAGES-deep synchronizer plus rise/fall pulse outputs), SHALL be instantiated twice, for ncs and sck.

Verification
REQ-031 Load 8'hA5, run master with half-period 25 clk -> master captures receive bits [12:5] = 8'hA5, frame_done pulses once, sdo shows 000 10100101 00000.
REQ-032 Load 8'hFF then 8'h3C in IDLE before one frame -> frame carries 8'h3C; sample_ready low throughout ncs low.
REQ-033 Raise ncs after 7 sck rising edges -> frame_abort one pulse, no frame_done, next frame retransmits the same hold value.
REQ-034 Two back-to-back frames with no new sample, hold 8'h81 -> both frames decode 8'h81, two frame_done pulses.
REQ-035 Assert rst_n low during bit 9 -> sdo = 0 and IDLE next cycle, no pulses; next full frame transmits 8'h00.
REQ-036 Extra sck edges after 16th rising edge while ncs low -> sdo stays 0, no second frame_done, DONE until ncs rises.
